// File: rtl/present_cbc_ctrl_pkg.sv
// Shared types and widths for the PRESENT-80 CBC mode controller.
package present_cbc_ctrl_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 80;

  typedef enum logic [2:0] {
    StKeyGen,
    StKeyWait,
    StIdle,
    StClear,
    StRun,
    StOut,
    StErr
  } state_t;

  typedef enum logic {
    CBC_ENC = 1'b0,
    CBC_DEC = 1'b1
  } cbc_mode_t;

endpackage

// File: rtl/present_cbc_ctrl_wdog.sv
// Clearable up-counter used as the core-run watchdog.
module present_cbc_ctrl_wdog #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/present_cbc_ctrl.sv
// CBC mode controller for a PRESENT-80 core: key schedule sequencing, chaining, core watchdog.
module present_cbc_ctrl #(
  parameter int unsigned BLOCK_W = present_cbc_ctrl_pkg::BLOCK_W,
  parameter int unsigned KEY_W   = present_cbc_ctrl_pkg::KEY_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               key_load,
  input  logic [BLOCK_W-1:0] iv_i,
  input  logic               iv_load,
  input  logic               mode_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic               err,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_key_rst,
  input  logic               core_key_done,
  output logic               core_enc_dec,
  output logic               core_run,
  output logic [BLOCK_W-1:0] core_block_i,
  input  logic [BLOCK_W-1:0] core_block_o,
  input  logic               core_done
);

  import present_cbc_ctrl_pkg::*;

  localparam int unsigned       WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT);

  state_t             state_q;
  logic [BLOCK_W-1:0] chain_q;
  logic [BLOCK_W-1:0] ibuf_q;
  logic [BLOCK_W-1:0] chain_eff;
  logic [WD_W-1:0]    wd_count;
  logic               wd_clr;
  logic               wd_en;

  // An IV loaded in the same cycle as an accepted block chains that block.
  always_comb begin
    chain_eff = iv_load ? iv_i : chain_q;
    wd_clr    = (state_q == StClear);
    wd_en     = (state_q == StRun);
  end

  present_cbc_ctrl_wdog #(
    .WIDTH (WD_W)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr),
    .en    (wd_en),
    .count (wd_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StKeyGen;
      core_key_rst <= 1'b1;
      core_run     <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b1;
      err          <= 1'b0;
      chain_q      <= '0;
      ibuf_q       <= '0;
      core_key     <= '0;
      core_block_i <= '0;
      out_data     <= '0;
      core_enc_dec <= 1'b0;
    end else begin
      case (state_q)
        StKeyGen: begin
          core_key_rst <= 1'b0;
          state_q      <= StKeyWait;
        end
        StKeyWait: begin
          if (core_key_done) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StIdle: begin
          if (key_load) begin
            core_key     <= key_i;
            err          <= 1'b0;
            core_key_rst <= 1'b1;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
            state_q      <= StKeyGen;
          end else begin
            if (iv_load) begin
              chain_q <= iv_i;
            end
            if (in_valid && in_ready) begin
              core_enc_dec <= mode_i;
              ibuf_q       <= in_data;
              core_block_i <= (cbc_mode_t'(mode_i) == CBC_ENC) ? (in_data ^ chain_eff) : in_data;
              in_ready     <= 1'b0;
              busy         <= 1'b1;
              state_q      <= StClear;
            end
          end
        end
        StClear: begin
          // core_run stays low one cycle so any stale core_done is flushed.
          core_run <= 1'b1;
          state_q  <= StRun;
        end
        StRun: begin
          if (core_done) begin
            if (cbc_mode_t'(core_enc_dec) == CBC_ENC) begin
              out_data <= core_block_o;
              chain_q  <= core_block_o;
            end else begin
              out_data <= core_block_o ^ chain_q;
              chain_q  <= ibuf_q;
            end
            core_run  <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= StOut;
          end else if (wd_count == WD_MAX) begin
            err      <= 1'b1;
            core_run <= 1'b0;
            state_q  <= StErr;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StErr: begin
          if (key_load) begin
            core_key     <= key_i;
            err          <= 1'b0;
            core_key_rst <= 1'b1;
            state_q      <= StKeyGen;
          end
        end
        default: begin
          core_key_rst <= 1'b1;
          core_run     <= 1'b0;
          in_ready     <= 1'b0;
          out_valid    <= 1'b0;
          busy         <= 1'b1;
          state_q      <= StKeyGen;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_cbc_ctrl.sv
// Randomised CBC bench: behavioural PRESENT-80 core stub plus a CBC reference model.
module tb_present_cbc_ctrl;

  localparam int unsigned TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] key_i;
  logic        key_load;
  logic [63:0] iv_i;
  logic        iv_load;
  logic        mode_i;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        err;
  logic [79:0] core_key;
  logic        core_key_rst;
  logic        core_key_done;
  logic        core_enc_dec;
  logic        core_run;
  logic [63:0] core_block_i;
  logic [63:0] core_block_o;
  logic        core_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [79:0] m_key;
  logic [63:0] m_chain;

  // Core stub controls
  int   core_lat    = 3;
  logic hang        = 1'b0;
  logic done_inject = 1'b0;
  int   kcnt;
  int   rcnt;
  logic done_q;

  always #5 clk = ~clk;

  present_cbc_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_i         (key_i),
    .key_load      (key_load),
    .iv_i          (iv_i),
    .iv_load       (iv_load),
    .mode_i        (mode_i),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .err           (err),
    .core_key      (core_key),
    .core_key_rst  (core_key_rst),
    .core_key_done (core_key_done),
    .core_enc_dec  (core_enc_dec),
    .core_run      (core_run),
    .core_block_i  (core_block_i),
    .core_block_o  (core_block_o),
    .core_done     (core_done)
  );

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h2174_8FE3_DA09_B65C;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [3:0] isb(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) if (sb(4'(j)) == x) r = 4'(j);
    return r;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s, input logic inv);
    logic [63:0] r;
    for (int j = 0; j < 16; j++) r[j*4 +: 4] = inv ? isb(s[j*4 +: 4]) : sb(s[j*4 +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s, input logic inv);
    logic [63:0] r;
    r[63] = s[63];
    for (int i = 0; i < 63; i++) begin
      if (inv) r[i] = s[(i * 16) % 63];
      else     r[(i * 16) % 63] = s[i];
    end
    return r;
  endfunction

  function automatic logic [79:0] next_key(input logic [79:0] k, input int rc);
    logic [79:0] n;
    logic [4:0]  c;
    c = 5'(rc);
    n = {k[18:0], k[79:19]};
    n[79:76] = sb(n[79:76]);
    n[19:15] = n[19:15] ^ c;
    return n;
  endfunction

  function automatic logic [63:0] present_enc(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] s;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = p_layer(s_layer(s ^ k[79:16], 1'b0), 1'b0);
      k = next_key(k, r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] present_dec(input logic [79:0] key, input logic [63:0] ct);
    logic [63:0] rk [33];
    logic [79:0] k;
    logic [63:0] s;
    k = key;
    rk[0] = '0;
    rk[1] = k[79:16];
    for (int r = 1; r <= 31; r++) begin
      k = next_key(k, r);
      rk[r+1] = k[79:16];
    end
    s = ct ^ rk[32];
    for (int r = 31; r >= 1; r--) s = s_layer(p_layer(s, 1'b1), 1'b1) ^ rk[r];
    return s;
  endfunction

  // ---------------- core stub ----------------
  always @(posedge clk) begin
    if (core_key_rst) begin
      kcnt          <= 0;
      core_key_done <= 1'b0;
    end else if (!core_key_done) begin
      kcnt <= kcnt + 1;
      if (kcnt == 4) core_key_done <= 1'b1;
    end
    if (!core_run) begin
      rcnt   <= 0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      rcnt <= rcnt + 1;
      if (rcnt + 1 >= core_lat && !hang) begin
        done_q       <= 1'b1;
        core_block_o <= core_enc_dec ? present_dec(core_key, core_block_i)
                                     : present_enc(core_key, core_block_i);
      end
    end
  end
  assign core_done = done_q | done_inject;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_ctl"}, {core_key_rst, core_run, in_ready, out_valid, busy, err, core_enc_dec},
          7'b1000100);
    check({pfx, "_key"}, core_key, 0);
    check({pfx, "_blk"}, core_block_i, 0);
    check({pfx, "_out"}, out_data, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic load_key(input logic [79:0] k);
    key_i    = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    m_key    = k;
    check("keygen_ctl", {core_key_rst, busy, err, in_ready}, 4'b1100);
    check("keygen_key", core_key, k);
    wait_idle();
  endtask

  task automatic load_iv(input logic [63:0] v);
    iv_i    = v;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    m_chain = v;
  endtask

  task automatic send_block(input logic mode, input logic [63:0] data, input int hold,
                            input logic with_iv, input logic [63:0] iv, input logic poke_key,
                            output logic [63:0] got);
    logic [63:0] exp;
    logic [63:0] ch;
    int          n;
    wait_idle();
    ch = with_iv ? iv : m_chain;
    if (mode == 1'b0) begin
      exp     = present_enc(m_key, data ^ ch);
      m_chain = exp;
    end else begin
      exp     = present_dec(m_key, data) ^ ch;
      m_chain = data;
    end
    mode_i   = mode;
    in_data  = data;
    iv_i     = iv;
    iv_load  = with_iv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    iv_load  = 1'b0;
    check("accept", {in_ready, busy}, 2'b01);
    if (poke_key) begin
      key_i    = ~m_key;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      check("key_ignored", core_key, m_key);
    end
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    check("out_valid", out_valid, 1);
    repeat (hold) tick();
    got = out_data;
    check("out_data", {out_valid, out_data}, {1'b1, exp});
    if (hold > 0) check("hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("back_idle", {in_ready, out_valid, busy}, 3'b100);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] got;
    logic [63:0] d;
    int          n;
    key_i     = '0;
    key_load  = 1'b0;
    iv_i      = '0;
    iv_load   = 1'b0;
    mode_i    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_key     = '0;
    m_chain   = '0;
    rst       = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset("por");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("keywait", {core_key_rst, busy}, 2'b01);
    wait_idle();

    // Known answer: key 0, iv 0, encrypt zero block
    send_block(1'b0, 64'h0, 0, 1'b0, 64'h0, 1'b0, got);
    check("kat_enc", got, 64'h5579C1387B228445);

    // Encrypt stream chaining
    load_iv(64'h0);
    send_block(1'b0, 64'h0, 1, 1'b0, 64'h0, 1'b0, got);
    check("stream0", got, 64'h5579C1387B228445);
    send_block(1'b0, 64'h5579C1387B228445, 0, 1'b0, 64'h0, 1'b0, got);
    check("stream1", got, 64'h5579C1387B228445);

    // Known answer decrypt, then a chained follow-up block
    load_key({80{1'b1}});
    load_iv(64'h0);
    send_block(1'b1, 64'h3333DCD3213210D2, 0, 1'b0, 64'h0, 1'b0, got);
    check("kat_dec", got, 64'hFFFFFFFFFFFFFFFF);
    send_block(1'b1, {$urandom, $urandom}, 0, 1'b0, 64'h0, 1'b0, got);

    // Long output backpressure
    send_block(1'b0, {$urandom, $urandom}, 20, 1'b0, 64'h0, 1'b0, got);

    // Spurious core_done while idle
    done_inject = 1'b1;
    repeat (3) tick();
    done_inject = 1'b0;
    check("stray_done", {in_ready, out_valid, busy}, 3'b100);

    // key_load while busy, iv_load together with a block
    send_block(1'b0, {$urandom, $urandom}, 0, 1'b0, 64'h0, 1'b1, got);
    send_block(1'b1, {$urandom, $urandom}, 0, 1'b1, {$urandom, $urandom}, 1'b0, got);
    send_block(1'b0, {$urandom, $urandom}, 0, 1'b1, {$urandom, $urandom}, 1'b0, got);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      core_lat = int'($urandom_range(1, 16));
      if ($urandom_range(0, 5) == 0) load_key({$urandom, $urandom, 16'($urandom)});
      send_block(1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), {$urandom, $urandom}, 1'b0, got);
    end

    // Watchdog timeout
    core_lat = 4;
    hang     = 1'b1;
    wait_idle();
    in_data  = {$urandom, $urandom};
    mode_i   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!core_run && n < 10) begin
      tick();
      n++;
    end
    check("wd_run", core_run, 1);
    n = 0;
    while (!err && n < int'(TIMEOUT) + 50) begin
      tick();
      n++;
    end
    check("wd_cycles", n, TIMEOUT + 1);
    check("err_state", {err, core_run, in_ready, out_valid, busy}, 5'b10001);
    hang = 1'b0;
    repeat (3) tick();
    check("err_sticky", err, 1);
    load_key({$urandom, $urandom, 16'($urandom)});
    send_block(1'b0, {$urandom, $urandom}, 0, 1'b0, 64'h0, 1'b0, got);

    // Reset in the middle of a run
    core_lat = 30;
    wait_idle();
    d        = {$urandom, $urandom};
    in_data  = d;
    mode_i   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!core_run && n < 10) begin
      tick();
      n++;
    end
    tick();
    rst = 1'b0;
    #1 check_reset("mid_rst");
    m_key   = '0;
    m_chain = '0;
    tick();
    rst      = 1'b1;
    core_lat = 5;
    tick();
    check("rec_keywait", {core_key_rst, busy}, 2'b01);
    send_block(1'b0, 64'h0, 0, 1'b0, 64'h0, 1'b0, got);
    check("rec_kat", got, 64'h5579C1387B228445);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
